// File: rtl/pow_seq.sv
// Iterative p**q sequencer driving an external multiplier; POW_SAT_EN selects saturating accumulate.
// Result valid q cycles after accept; holds result in DONE under unbounded out_ready backpressure.
module pow_seq #(
  parameter int DATA_W = 8,
  parameter int Q_W    = 3,
  parameter int RES_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       p_in,
  input  logic [Q_W-1:0]          q_in,
  output logic [RES_W-1:0]        mul_a,
  output logic [DATA_W-1:0]       mul_b,
  input  logic [RES_W+DATA_W-1:0] mul_p,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RES_W-1:0]        result,
  output logic                    ovf,
  output logic                    busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [RES_W-1:0]  acc;
  logic [DATA_W-1:0] p_reg;
  logic [Q_W-1:0]    cnt;
  logic              mul_hi;

  assign mul_hi = (mul_p[RES_W+DATA_W-1:RES_W] != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      acc   <= '0;
      p_reg <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            p_reg <= p_in;
            cnt   <= q_in;
            acc   <= RES_W'(1);
            ovf   <= 1'b0;
            state <= (q_in == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
`ifdef POW_SAT_EN
          // Once saturated, ovf is set and the accumulator stays pinned at all-ones.
          if (ovf || mul_hi)
            acc <= '1;
          else
            acc <= mul_p[RES_W-1:0];
`else
          acc <= mul_p[RES_W-1:0];
`endif
          if (mul_hi)
            ovf <= 1'b1;
          if (cnt == Q_W'(1))
            state <= DONE;
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = acc;
  assign mul_a     = acc;
  assign mul_b     = p_reg;

endmodule

// File: tb/tb_pow_seq.sv
// Scoreboard bench for pow_seq: expected results queued at accept, checked while out_valid is high.
module tb_pow_seq;

  localparam int DATA_W = 8;
  localparam int Q_W    = 3;
  localparam int RES_W  = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       p_in;
  logic [Q_W-1:0]          q_in;
  logic [RES_W-1:0]        mul_a;
  logic [DATA_W-1:0]       mul_b;
  logic [RES_W+DATA_W-1:0] mul_p;
  logic                    out_valid;
  logic                    out_ready;
  logic [RES_W-1:0]        result;
  logic                    ovf;
  logic                    busy;

  pow_seq #(.DATA_W(DATA_W), .Q_W(Q_W), .RES_W(RES_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .p_in(p_in), .q_in(q_in), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .ovf(ovf), .busy(busy)
  );

  // External combinational multiplier at full product width
  assign mul_p = (RES_W+DATA_W)'(mul_a) * (RES_W+DATA_W)'(mul_b);

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [RES_W-1:0] res;
    logic             ov;
    int               due;
  } exp_t;

  exp_t sb[$];
  logic seen_valid = 1'b0;
  int   last_hs    = -100;

  function automatic exp_t model(input logic [DATA_W-1:0] p, input logic [Q_W-1:0] q);
    exp_t e;
    logic [RES_W+DATA_W-1:0] prod;
    e.res = RES_W'(1);
    e.ov  = 1'b0;
    e.due = 0;
    for (int i = 0; i < int'(q); i++) begin
      prod = (RES_W+DATA_W)'(e.res) * (RES_W+DATA_W)'(p);
`ifdef POW_SAT_EN
      if (e.ov || prod[RES_W+DATA_W-1:RES_W] != '0) e.res = '1;
      else e.res = prod[RES_W-1:0];
`else
      e.res = prod[RES_W-1:0];
`endif
      if (prod[RES_W+DATA_W-1:RES_W] != '0) e.ov = 1'b1;
    end
    return e;
  endfunction

  // Monitor: sample on the falling edge, away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      sb.delete();
      seen_valid = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        e = model(p_in, q_in);
        e.due = cyc + 1 + int'(q_in);
        sb.push_back(e);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          if (!seen_valid) begin
            check("latency", 32'(cyc), 32'(sb[0].due));
            seen_valid = 1'b1;
          end
          check("result", 32'(result), 32'(sb[0].res));
          check("ovf", 32'(ovf), 32'(sb[0].ov));
          check("in_ready_in_done", 32'(in_ready), 32'd0);
          if (out_ready) begin
            void'(sb.pop_front());
            seen_valid = 1'b0;
            last_hs    = cyc + 1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands until accepted; returns the edge number of the accept
  task automatic accept(input logic [DATA_W-1:0] p, input logic [Q_W-1:0] q,
                        input logic keep, output int edge_no);
    logic rdy;
    logic ok = 1'b0;
    p_in     = p;
    q_in     = q;
    in_valid = 1'b1;
    edge_no  = -1;
    for (int n = 0; n < 50 && !ok; n++) begin
      rdy = in_ready;
      tick();
      if (rdy) begin
        ok      = 1'b1;
        edge_no = cyc;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    logic ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      if (out_valid) ok = 1'b1;
      else tick();
    end
    if (!ok) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    wait_valid();
    tick();
  endtask

  int e1, e2, e3;

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    p_in      = '0;
    q_in      = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_mul_a", 32'(mul_a), 32'd0);
    check("rst_mul_b", 32'(mul_b), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b1;
    tick();

    // 3**4 with immediate consumer
    accept(8'd3, 3'd4, 1'b0, e1);
    check("run_mul_a", 32'(mul_a), 32'd1);
    check("run_mul_b", 32'(mul_b), 32'd3);
    check("run_busy", 32'(busy), 32'd1);
    wait_done();
    check("idle_after_hs", 32'(in_ready), 32'd1);
    check("busy_after_hs", 32'(busy), 32'd0);

    // Zero base / zero exponent corners
    accept(8'd0, 3'd0, 1'b0, e1);
    wait_done();
    accept(8'd0, 3'd3, 1'b0, e1);
    wait_done();
    accept(8'd1, 3'd7, 1'b0, e1);
    wait_done();

    // Overflow: wraps or saturates depending on build
    accept(8'd255, 3'd3, 1'b0, e1);
    wait_done();
    accept(8'd200, 3'd7, 1'b0, e1);
    wait_done();

    // Backpressure in DONE with new operands offered
    out_ready = 1'b0;
    accept(8'd2, 3'd7, 1'b0, e1);
    wait_valid();
    p_in     = 8'd9;
    q_in     = 3'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    check("bp_release_idle", 32'(in_ready), 32'd1);

    // Reset mid-RUN discards the operation
    accept(8'd5, 3'd6, 1'b0, e1);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    accept(8'd2, 3'd5, 1'b0, e1);
    wait_done();

    // Back-to-back operands with in_valid held high
    accept(8'd2, 3'd3, 1'b1, e1);
    accept(8'd3, 3'd2, 1'b1, e2);
    check("b2b_gap_1", 32'(e2), 32'(last_hs + 1));
    accept(8'd7, 3'd1, 1'b0, e3);
    check("b2b_gap_2", 32'(e3), 32'(last_hs + 1));
    wait_done();

    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
